// File: rtl/ddr_cmd_pkg.sv
// ddr_cmd_pkg
//   Shared definitions for the scheduler word format: DDR4 command type codes,
//   the 32-bit slot field layout, slot count and pack-register states.
//   Imported by cmd_slot_pack and cmd_encoder.
package ddr_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_PRE = 3'd1,
        CMD_ACT = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4,
        CMD_REF = 3'd5,
        CMD_ZQ  = 3'd6
    } cmd_type_e;

    localparam int SLOT_WIDTH = 32;
    localparam int TYPE_LSB   = 0;
    localparam int BANK_LSB   = 3;
    localparam int BG_LSB     = 5;
    localparam int ADDR_LSB   = 7;
    localparam int ADDR_BITS  = 17;   // slot bits [23:7]
    localparam int NUM_SLOTS  = 4;
    localparam int CMD_WIDTH  = NUM_SLOTS * SLOT_WIDTH;

    typedef enum logic [1:0] {
        PK_EMPTY   = 2'd0,
        PK_FILLING = 2'd1,
        PK_CLOSED  = 2'd2
    } pack_state_e;

endpackage

// File: rtl/cmd_slot_pack.sv
// cmd_slot_pack
//   Combinational formatter: one command -> one 32-bit scheduler slot.
//   Slot layout: [2:0] type, [4:3] bank, [6:5] bg, [23:7] addr, [31:24] zero.
// Ports
//   cmd_type  in   3            command type code (7 is encoded as NOP)
//   bank      in   BANK_WIDTH   bank
//   bg        in   BG_WIDTH     bank group
//   addr      in   ROW_WIDTH    row / column / PALL bit depending on type
//   slot      out  SLOT_WIDTH   formatted slot
module cmd_slot_pack
    import ddr_cmd_pkg::*;
#(
    parameter int BG_WIDTH   = 2,
    parameter int BANK_WIDTH = 2,
    parameter int ROW_WIDTH  = 17,
    parameter int COL_WIDTH  = 10
) (
    input  logic [2:0]            cmd_type,
    input  logic [BANK_WIDTH-1:0] bank,
    input  logic [BG_WIDTH-1:0]   bg,
    input  logic [ROW_WIDTH-1:0]  addr,
    output logic [SLOT_WIDTH-1:0] slot
);

    logic [ADDR_BITS-1:0] afield;
    logic                 valid_cmd;

    always_comb begin
        afield    = '0;
        valid_cmd = 1'b1;
        case (cmd_type)
            CMD_ACT:        afield[ROW_WIDTH-1:0] = addr;
            CMD_RD, CMD_WR: afield[COL_WIDTH-1:0] = addr[COL_WIDTH-1:0];
            // bit 7 of the slot carries PALL, everything above is zero
            CMD_PRE:        afield[0] = addr[0];
            CMD_REF, CMD_ZQ: afield = '0;
            // NOP and the reserved code 7 collapse to an all-zero slot
            default:        valid_cmd = 1'b0;
        endcase

        slot = '0;
        if (valid_cmd) begin
            slot[TYPE_LSB +: 3]          = cmd_type;
            slot[BANK_LSB +: BANK_WIDTH] = bank;
            slot[BG_LSB +: BG_WIDTH]     = bg;
            slot[ADDR_LSB +: ADDR_BITS]  = afield;
        end
    end

endmodule

// File: rtl/cmd_encoder.sv
// cmd_encoder
//   Packs single DDR4 commands (plus write data) into 640-bit scheduler words:
//   [127:0] = four 32-bit command slots (slot 0 first), [639:128] = write data
//   of the word's single WR (zero if none). Unused slots are NOP (zero).
//   A word closes when its fourth slot fills, on in_last, when a second WR
//   arrives, or after FLUSH_TIMEOUT idle cycles while partially filled.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     command handshake
//   in_type/bank/bg/addr  command fields, in_wdata sampled only with WR
//   in_last               close the word after this command
//   out_valid/out_ready   packed-word handshake
//   out_data              packed word, held while out_valid && !out_ready
//   stat_words/cmds/flush statistics, present only with ENC_STATS_EN defined
// Configuration
//   ENC_STATS_EN : adds the three wrapping statistics counters and ports.
module cmd_encoder
    import ddr_cmd_pkg::*;
#(
    parameter int BG_WIDTH      = 2,
    parameter int BANK_WIDTH    = 2,
    parameter int ROW_WIDTH     = 17,
    parameter int COL_WIDTH     = 10,
    parameter int WDATA_WIDTH   = 512,
    parameter int FLUSH_TIMEOUT = 16,
    parameter int TO_WIDTH      = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [2:0]                       in_type,
    input  logic [BANK_WIDTH-1:0]            in_bank,
    input  logic [BG_WIDTH-1:0]              in_bg,
    input  logic [ROW_WIDTH-1:0]             in_addr,
    input  logic [WDATA_WIDTH-1:0]           in_wdata,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CMD_WIDTH+WDATA_WIDTH-1:0] out_data
`ifdef ENC_STATS_EN
    ,
    output logic [31:0]                      stat_words,
    output logic [31:0]                      stat_cmds,
    output logic [15:0]                      stat_flush
`endif
);

    // ---------------------------------------------------------------
    // Pack register
    // ---------------------------------------------------------------
    pack_state_e                          state;
    logic [NUM_SLOTS-1:0][SLOT_WIDTH-1:0] slots;
    logic [WDATA_WIDTH-1:0]               wdata;
    logic [2:0]                           cnt;
    logic                                 has_wr;
    logic [TO_WIDTH-1:0]                  idle;
    logic                                 rdy_en;

    logic [SLOT_WIDTH-1:0] slot_new;
    logic                  is_wr;
    logic                  out_free;
    logic                  wr_conflict;
    logic                  accept;
    logic                  flush_hit;

    cmd_slot_pack #(
        .BG_WIDTH   (BG_WIDTH),
        .BANK_WIDTH (BANK_WIDTH),
        .ROW_WIDTH  (ROW_WIDTH),
        .COL_WIDTH  (COL_WIDTH)
    ) u_slot (
        .cmd_type (in_type),
        .bank     (in_bank),
        .bg       (in_bg),
        .addr     (in_addr),
        .slot     (slot_new)
    );

    assign is_wr    = (in_type == CMD_WR);
    assign out_free = !out_valid || out_ready;

    // A CLOSED word is always replaced by a fresh one before accepting, so a
    // WR can only conflict with a word that is still filling.
    assign wr_conflict = in_valid && is_wr && has_wr && (state == PK_FILLING);

    // rdy_en keeps in_ready low during reset and until the first edge after it.
    assign in_ready = rdy_en && ((state != PK_CLOSED) || out_free) && !wr_conflict;
    assign accept   = in_valid && in_ready;

    assign flush_hit = (FLUSH_TIMEOUT != 0) && (state == PK_FILLING) &&
                       (idle == TO_WIDTH'(FLUSH_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= PK_EMPTY;
            slots  <= '0;
            wdata  <= '0;
            cnt    <= '0;
            has_wr <= 1'b0;
            idle   <= '0;
        end else if (state == PK_CLOSED) begin
            if (out_free) begin
                // word leaves for the output register; start a fresh one,
                // optionally seeding slot 0 with this cycle's command
                slots  <= '0;
                wdata  <= '0;
                cnt    <= '0;
                has_wr <= 1'b0;
                idle   <= '0;
                state  <= PK_EMPTY;
                if (accept) begin
                    slots[0] <= slot_new;
                    cnt      <= 3'd1;
                    has_wr   <= is_wr;
                    if (is_wr) begin
                        wdata <= in_wdata;
                    end
                    state <= in_last ? PK_CLOSED : PK_FILLING;
                end
            end
        end else if (accept) begin
            slots[cnt[1:0]] <= slot_new;
            cnt             <= cnt + 3'd1;
            idle            <= '0;
            if (is_wr) begin
                has_wr <= 1'b1;
                wdata  <= in_wdata;
            end
            state <= (in_last || cnt == 3'd3) ? PK_CLOSED : PK_FILLING;
        end else if (wr_conflict || flush_hit) begin
            idle  <= '0;
            state <= PK_CLOSED;
        end else if (state == PK_FILLING && FLUSH_TIMEOUT != 0) begin
            idle <= idle + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Output register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (state == PK_CLOSED && out_free) begin
            out_valid <= 1'b1;
            out_data  <= {wdata, slots};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ENC_STATS_EN
    // ---------------------------------------------------------------
    // Statistics (free-running, wrap at maximum)
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words <= '0;
            stat_cmds  <= '0;
            stat_flush <= '0;
        end else begin
            if (out_valid && out_ready) begin
                stat_words <= stat_words + 32'd1;
            end
            if (accept) begin
                stat_cmds <= stat_cmds + 32'd1;
            end
            if (flush_hit && !accept) begin
                stat_flush <= stat_flush + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmd_encoder.sv
module tb_cmd_encoder;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_type;
    logic [1:0]   in_bank;
    logic [1:0]   in_bg;
    logic [16:0]  in_addr;
    logic [511:0] in_wdata;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [639:0] out_data;

    int checks   = 0;
    int failures = 0;
    logic [639:0] sb_q[$];

    localparam logic [511:0] JUNK = {16{32'h1234_5678}};
    localparam logic [511:0] WD_A = {64{8'hA5}};
    localparam logic [511:0] WD_B = {16{32'hDEAD_BEEF}};

    cmd_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_bank   (in_bank),
        .in_bg     (in_bg),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected slot built straight from the slot format rules.
    function automatic logic [31:0] mk_slot(input logic [2:0] t, input logic [1:0] bank,
                                            input logic [1:0] bg, input logic [16:0] addr);
        logic [31:0] s;
        logic [16:0] a;
        s = '0;
        a = '0;
        case (t)
            3'd2:       a = addr;
            3'd3, 3'd4: a = {7'd0, addr[9:0]};
            3'd1:       a = {16'd0, addr[0]};
            default:    a = '0;
        endcase
        if (t != 3'd0 && t != 3'd7) begin
            s[2:0]  = t;
            s[4:3]  = bank;
            s[6:5]  = bg;
            s[23:7] = a;
        end
        return s;
    endfunction

    // Scoreboard monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", out_data, 640'd0);
            end else begin
                chk("word", out_data, sb_q.pop_front());
            end
        end
    end

    task automatic send(input logic [2:0] t, input logic [1:0] bank, input logic [1:0] bg,
                        input logic [16:0] addr, input logic [511:0] wd, input logic last,
                        output int waited);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_type  = t;
        in_bank  = bank;
        in_bg    = bg;
        in_addr  = addr;
        in_wdata = wd;
        in_last  = last;
        ok = 0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", 640'd0, 640'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_wdata = JUNK;
        waited   = n;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
        chk("sb_empty", 640'(sb_q.size()), 640'd0);
    endtask

    logic [2:0]   bt[12];
    logic [1:0]   bb[12];
    logic [1:0]   bgg[12];
    logic [16:0]  ba[12];

    initial begin
        int w, wsum, lat, acc;
        bit fire;
        logic [639:0] held;

        rst_n = 1'b0; in_valid = 1'b0; in_type = '0; in_bank = '0; in_bg = '0;
        in_addr = '0; in_wdata = JUNK; in_last = 1'b0; out_ready = 1'b1;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 640'(in_ready), 640'd0);
        chk("rst_out_valid", 640'(out_valid), 640'd0);
        chk("rst_out_data", out_data, 640'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("pre_edge_in_ready", 640'(in_ready), 640'd0);
        @(posedge clk); #1;
        chk("post_edge_in_ready", 640'(in_ready), 640'd1);

        // ---- ACT, RD, PRE, REF back to back ----
        sb_q.push_back({512'd0,
                        mk_slot(3'd5, 2'd2, 2'd3, 17'h12345),
                        mk_slot(3'd1, 2'd0, 2'd1, 17'h00003),
                        mk_slot(3'd3, 2'd3, 2'd1, 17'h1F3FF),
                        mk_slot(3'd2, 2'd1, 2'd2, 17'h1ABCD)});
        wsum = 0;
        send(3'd2, 2'd1, 2'd2, 17'h1ABCD, JUNK, 1'b0, w); wsum += w;
        send(3'd3, 2'd3, 2'd1, 17'h1F3FF, JUNK, 1'b0, w); wsum += w;
        send(3'd1, 2'd0, 2'd1, 17'h00003, JUNK, 1'b0, w); wsum += w;
        send(3'd5, 2'd2, 2'd3, 17'h12345, JUNK, 1'b0, w); wsum += w;
        chk("b2b_cycles", 640'(wsum), 640'd4);
        drain();

        // ---- single WR with in_last ----
        sb_q.push_back({WD_A, 96'd0, mk_slot(3'd4, 2'd1, 2'd0, 17'h155)});
        send(3'd4, 2'd1, 2'd0, 17'h155, WD_A, 1'b1, w);
        drain();

        // ---- WR, WR: second WR stalls one cycle and starts word 2 ----
        sb_q.push_back({WD_A, 96'd0, mk_slot(3'd4, 2'd2, 2'd1, 17'h0AA)});
        sb_q.push_back({WD_B, 96'd0, mk_slot(3'd4, 2'd3, 2'd2, 17'h3C1)});
        send(3'd4, 2'd2, 2'd1, 17'h0AA, WD_A, 1'b0, w);
        send(3'd4, 2'd3, 2'd2, 17'h3C1, WD_B, 1'b1, w);
        chk("wr_conflict_wait", 640'(w), 640'd2);
        drain();

        // ---- one ACT then idle: timeout flush ----
        sb_q.push_back({512'd0, 96'd0, mk_slot(3'd2, 2'd0, 2'd3, 17'h00777)});
        send(3'd2, 2'd0, 2'd3, 17'h00777, JUNK, 1'b0, w);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk("flush_not_early", 640'(lat > 16), 640'd1);
        chk("flush_not_late", 640'(lat <= 20), 640'd1);
        drain();

        // ---- backpressure: out_ready low for 20 cycles, 12 commands ----
        for (int i = 0; i < 12; i++) begin
            bt[i]  = (i % 2 == 0) ? 3'd2 : 3'd3;
            bb[i]  = 2'(i % 4);
            bgg[i] = 2'((i / 4) % 4);
            ba[i]  = 17'(i * 'h111 + 5);
        end
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back({512'd0,
                            mk_slot(bt[4*k+3], bb[4*k+3], bgg[4*k+3], ba[4*k+3]),
                            mk_slot(bt[4*k+2], bb[4*k+2], bgg[4*k+2], ba[4*k+2]),
                            mk_slot(bt[4*k+1], bb[4*k+1], bgg[4*k+1], ba[4*k+1]),
                            mk_slot(bt[4*k],   bb[4*k],   bgg[4*k],   ba[4*k])});
        end
        out_ready = 1'b0;
        acc = 0;
        held = '0;
        in_valid = 1'b1; in_type = bt[0]; in_bank = bb[0]; in_bg = bgg[0]; in_addr = ba[0];
        for (int c = 0; c < 80 && acc < 12; c++) begin
            @(negedge clk);
            if (c == 10) held = out_data;
            if (c == 19) begin
                chk("bp_accepted", 640'(acc), 640'd8);
                chk("bp_in_ready", 640'(in_ready), 640'd0);
                chk("bp_out_valid", 640'(out_valid), 640'd1);
                chk("bp_out_stable", out_data, held);
            end
            fire = in_ready;
            @(posedge clk); #1;
            if (fire) begin
                acc++;
                if (acc < 12) begin
                    in_type = bt[acc]; in_bank = bb[acc]; in_bg = bgg[acc]; in_addr = ba[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (c == 19) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 640'(acc), 640'd12);
        drain();

        // ---- reset with a held word and a partial word ----
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(bt[i], bb[i], bgg[i], ba[i], JUNK, 1'b0, w);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 640'(out_valid), 640'd0);
        chk("mid_rst_out_data", out_data, 640'd0);
        chk("mid_rst_in_ready", 640'(in_ready), 640'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready_back", 640'(in_ready), 640'd1);
        sb_q.push_back({512'd0, 96'd0, mk_slot(3'd6, 2'd1, 2'd1, 17'h0F0F0)});
        send(3'd6, 2'd1, 2'd1, 17'h0F0F0, JUNK, 1'b1, w);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
